// File: rtl/serial_dp_pkg.sv
// -----------------------------------------------------------------------------
// serial_dp_pkg
// Shared definitions for the bit-serial dot-product stimulus/response engine.
//   - state_e       : driver FSM states (IDLE, SHIFT, WAIT, RESP)
//   - DEF_*         : default operand/result geometry and Done timeout
//   - frame_w()     : serial frame width for a given operand geometry
// -----------------------------------------------------------------------------
package serial_dp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int DEF_NUM_ELEM = 8;
    localparam int DEF_ELEM_W   = 8;
    localparam int DEF_RES_W    = 19;
    localparam int DEF_TIMEOUT  = 256;

    // A frame carries both operand vectors back to back: {B, A}.
    function automatic int frame_w(input int num_elem, input int elem_w);
        return 2 * num_elem * elem_w;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// -----------------------------------------------------------------------------
// piso_shift_reg
// Parallel-in, serial-out shift register. Bit 0 is presented first; each shift
// moves the word right by one and fills the MSB with zero.
// Ports:
//   clk_i    : clock, posedge
//   rst_i    : synchronous active-high reset (register cleared)
//   load_i   : load data_i (has priority over shift_i)
//   data_i   : parallel word, WIDTH bits
//   shift_i  : shift right by one, zero fill
//   serial_o : current LSB of the register
// -----------------------------------------------------------------------------
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             shift_i,
    output logic             serial_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign serial_o = sr_q[0];

endmodule

// File: rtl/serial_vector_driver.sv
// -----------------------------------------------------------------------------
// serial_vector_driver
// Serial stimulus/response engine for the bit-serial dot-product core. Accepts
// an operand pair on a valid/ready port, shifts the frame {vec_b, vec_a}
// LSB-first on SerialData with a one-cycle Start coincident with bit 0, waits
// for Done (bounded by TIMEOUT cycles) and reports the captured result.
//
// Optional feature: define SERIAL_VECTOR_DRIVER_CHECK_EN to compare each result
// against exp_result (latched with the vector) and count errors. Without it,
// mismatch and err_count are tied to 0 and exp_result is ignored.
//
// Ports:
//   clk, Reset            : clock / synchronous active-high reset
//   vec_valid, vec_ready  : load handshake; vec_ready only in IDLE, not in Reset
//   vec_a, vec_b          : operand vectors, element 0 in LSBs
//   exp_result            : expected result, sampled on accept (CHECK_EN)
//   SerialData, Start     : serial frame and one-cycle frame start to core
//   DataOut, Done         : core result and its valid strobe
//   res_valid             : one-cycle result strobe (in RESP)
//   res_data, res_timeout : captured result (0 on timeout) and timeout flag
//   mismatch, err_count   : CHECK_EN result check and saturating error count
//   dbg_state_o           : current FSM state (serial_dp_pkg::state_e encoding)
//
// Handshake: a vector is transferred on the posedge where vec_valid and
// vec_ready are both high; vec_a/vec_b/exp_result are sampled on that edge and
// the source may change them from the next cycle on.
// -----------------------------------------------------------------------------
module serial_vector_driver
    import serial_dp_pkg::*;
#(
    parameter int NUM_ELEM = DEF_NUM_ELEM,
    parameter int ELEM_W   = DEF_ELEM_W,
    parameter int RES_W    = DEF_RES_W,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic                       vec_valid,
    output logic                       vec_ready,
    input  logic [NUM_ELEM*ELEM_W-1:0] vec_a,
    input  logic [NUM_ELEM*ELEM_W-1:0] vec_b,
    input  logic [RES_W-1:0]           exp_result,
    output logic                       SerialData,
    output logic                       Start,
    input  logic [RES_W-1:0]           DataOut,
    input  logic                       Done,
    output logic                       res_valid,
    output logic [RES_W-1:0]           res_data,
    output logic                       res_timeout,
    output logic                       mismatch,
    output logic [15:0]                err_count,
    output logic [1:0]                 dbg_state_o
);

    localparam int FRAME_W = frame_w(NUM_ELEM, ELEM_W);
    localparam int CNT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int TMR_W   = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
    localparam logic [TMR_W-1:0] LAST_TMR = TMR_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [RES_W-1:0]  res_data_q, res_data_d;
    logic              res_timeout_q, res_timeout_d;

    logic              accept;
    logic              shift_en;
    logic              ser_bit;

    // Ready is gated by Reset so no vector is offered during a reset cycle.
    assign vec_ready = (state_q == IDLE) && !Reset;
    assign accept    = vec_valid && vec_ready;

    piso_shift_reg #(
        .WIDTH (FRAME_W)
    ) u_piso (
        .clk_i    (clk),
        .rst_i    (Reset),
        .load_i   (accept),
        .data_i   ({vec_b, vec_a}),
        .shift_i  (shift_en),
        .serial_o (ser_bit)
    );

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        timer_d       = timer_q;
        res_data_d    = res_data_q;
        res_timeout_d = res_timeout_q;
        shift_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // The register LSB is on the wire this cycle; advance at the edge.
                shift_en  = 1'b1;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    timer_d   = '0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                // Done is checked first so it wins over a same-cycle timeout.
                if (Done) begin
                    res_data_d    = DataOut;
                    res_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (timer_q == LAST_TMR) begin
                    res_data_d    = '0;
                    res_timeout_d = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            timer_q       <= '0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            timer_q       <= timer_d;
            res_data_q    <= res_data_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    // Strobes decode from state and are forced low while Reset is asserted.
    assign Start       = !Reset && (state_q == SHIFT) && (bit_cnt_q == '0);
    assign SerialData  = !Reset && (state_q == SHIFT) && ser_bit;
    assign res_valid   = !Reset && (state_q == RESP);
    assign res_data    = res_data_q;
    assign res_timeout = res_timeout_q;
    assign dbg_state_o = state_q;

`ifdef SERIAL_VECTOR_DRIVER_CHECK_EN
    logic [RES_W-1:0] exp_q, exp_d;
    logic [15:0]      err_q, err_d;
    logic             mismatch_raw;

    assign mismatch_raw = (state_q == RESP) && (res_timeout_q || (res_data_q != exp_q));

    always_comb begin
        exp_d = exp_q;
        err_d = err_q;
        if (accept) begin
            exp_d = exp_result;
        end
        // Saturate so a long soak never wraps back to a clean-looking count.
        if (mismatch_raw && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            exp_q <= '0;
            err_q <= '0;
        end else begin
            exp_q <= exp_d;
            err_q <= err_d;
        end
    end

    assign mismatch  = !Reset && mismatch_raw;
    assign err_count = err_q;
`else
    logic unused_exp;
    assign unused_exp = ^exp_result;
    assign mismatch   = 1'b0;
    assign err_count  = 16'd0;
`endif

endmodule

// File: tb/tb_serial_vector_driver.sv
module tb_serial_vector_driver;

  localparam int NUM_ELEM = 8;
  localparam int ELEM_W   = 8;
  localparam int RES_W    = 19;
  localparam int TIMEOUT  = 16;
  localparam int VEC_W    = NUM_ELEM * ELEM_W;
  localparam int FRAME_W  = 2 * VEC_W;

`ifdef SERIAL_VECTOR_DRIVER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             Reset;
  logic             vec_valid;
  logic             vec_ready;
  logic [VEC_W-1:0] vec_a;
  logic [VEC_W-1:0] vec_b;
  logic [RES_W-1:0] exp_result;
  logic             SerialData;
  logic             Start;
  logic [RES_W-1:0] DataOut = '0;
  logic             Done = 1'b0;
  logic             res_valid;
  logic [RES_W-1:0] res_data;
  logic             res_timeout;
  logic             mismatch;
  logic [15:0]      err_count;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  serial_vector_driver #(
    .NUM_ELEM (NUM_ELEM),
    .ELEM_W   (ELEM_W),
    .RES_W    (RES_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .vec_valid   (vec_valid),
    .vec_ready   (vec_ready),
    .vec_a       (vec_a),
    .vec_b       (vec_b),
    .exp_result  (exp_result),
    .SerialData  (SerialData),
    .Start       (Start),
    .DataOut     (DataOut),
    .Done        (Done),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_timeout (res_timeout),
    .mismatch    (mismatch),
    .err_count   (err_count),
    .dbg_state_o (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_err = 0;

  // ---------------- core model + monitor (negedge) ----------------
  // Core: collects FRAME_W bits after Start, then raises Done after the
  // per-frame latency (0 = never). Monitor: records Start cycles, frames,
  // responses, ready cycles and stray SerialData bits.
  int               core_lat_q[$];
  logic [RES_W-1:0] core_res_q[$];
  logic [FRAME_W-1:0] frames_q[$];
  int               start_cyc_q[$];
  int               resp_cyc_q[$];
  logic [RES_W-1:0] resp_data_q[$];
  logic             resp_to_q[$];
  logic             resp_mm_q[$];
  int               spur_bit = -1;
  int               ready_cycles = 0;
  int               sd_stray = 0;

  bit                 collecting = 1'b0;
  int                 bitpos = 0;
  logic [FRAME_W-1:0] cur_frame = '0;
  int                 wait_cnt = 0;
  logic [RES_W-1:0]   pend_res = '0;

  always @(negedge clk) begin
    Done = 1'b0;
    if (Reset) begin
      collecting = 1'b0;
      wait_cnt = 0;
      core_lat_q.delete();
      core_res_q.delete();
      frames_q.delete();
      start_cyc_q.delete();
      resp_cyc_q.delete();
      resp_data_q.delete();
      resp_to_q.delete();
      resp_mm_q.delete();
    end else begin
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          Done = 1'b1;
          DataOut = pend_res;
        end
      end
      if (Start) begin
        collecting = 1'b1;
        bitpos = 0;
        start_cyc_q.push_back(cyc);
      end
      if (collecting) begin
        cur_frame[bitpos] = SerialData;
        if (spur_bit == bitpos) begin
          Done = 1'b1;
          DataOut = '1;
        end
        bitpos++;
        if (bitpos == FRAME_W) begin
          collecting = 1'b0;
          frames_q.push_back(cur_frame);
          wait_cnt = (core_lat_q.size() > 0) ? core_lat_q.pop_front() : 0;
          pend_res = (core_res_q.size() > 0) ? core_res_q.pop_front() : '0;
        end
      end else if (SerialData) begin
        sd_stray++;
      end
      if (res_valid) begin
        resp_cyc_q.push_back(cyc);
        resp_data_q.push_back(res_data);
        resp_to_q.push_back(res_timeout);
        resp_mm_q.push_back(mismatch);
      end
      if (vec_ready) ready_cycles++;
    end
  end

  // ---------------- reference model ----------------
  function automatic bit model_timeout(input int lat);
    return (lat == 0) || (lat > TIMEOUT);
  endfunction

  // Accept edge ends cycle acc; Start at acc+1; last bit at acc+FRAME_W;
  // result strobe one cycle after Done, or TIMEOUT cycles into the wait.
  function automatic int model_resp_cyc(input int acc, input int lat);
    return acc + FRAME_W + (model_timeout(lat) ? TIMEOUT : lat) + 1;
  endfunction

  task automatic model_resp(input int lat, input logic [RES_W-1:0] r, input logic [RES_W-1:0] e,
                            output logic to, output logic [RES_W-1:0] rd, output logic mm);
    to = model_timeout(lat);
    rd = to ? '0 : r;
    mm = CHK && (to || (rd != e));
    if (mm && exp_err < 65535) exp_err++;
  endtask

  // ---------------- driver tasks (start/end at posedge+1) ----------------
  task automatic drive_vec(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                           input logic [RES_W-1:0] e, input bit hold, output int acc);
    vec_a = a;
    vec_b = b;
    exp_result = e;
    vec_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (vec_ready) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    if (!hold) vec_valid = 1'b0;
  endtask

  task automatic wait_resp(output bit got, output int rc, output logic [RES_W-1:0] rd,
                           output logic rt, output logic rm);
    got = 1'b0;
    rc = -1;
    rd = 'x;
    rt = 1'bx;
    rm = 1'bx;
    for (int i = 0; i < 600; i++) begin
      if (resp_cyc_q.size() > 0) begin
        got = 1'b1;
        rc = resp_cyc_q.pop_front();
        rd = resp_data_q.pop_front();
        rt = resp_to_q.pop_front();
        rm = resp_mm_q.pop_front();
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_frame(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                          input logic [RES_W-1:0] e, input int lat, input logic [RES_W-1:0] r,
                          output int acc, output bit got, output int rc,
                          output logic [RES_W-1:0] rd, output logic rt, output logic rm);
    core_lat_q.push_back(lat);
    core_res_q.push_back(r);
    drive_vec(a, b, e, 1'b0, acc);
    wait_resp(got, rc, rd, rt, rm);
  endtask

  function automatic logic [FRAME_W-1:0] pop_frame();
    return (frames_q.size() > 0) ? frames_q.pop_front() : 'x;
  endfunction

  function automatic int pop_start();
    return (start_cyc_q.size() > 0) ? start_cyc_q.pop_front() : -1;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [RES_W+22:0] outs;
    Reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    outs = {vec_ready, Start, SerialData, res_valid, res_timeout, mismatch, res_data, err_count};
    n_tests++;
    if (outs !== '0 || dbg_state !== serial_dp_pkg::IDLE) begin
      n_fail++;
      $display("FAIL reset_outputs: got outs=%h state=%0d, want outs=0 state=0", outs, dbg_state);
    end
    @(posedge clk); #1;
    Reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (vec_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got vec_ready=%b, want 1", vec_ready);
    end
    @(posedge clk); #1;
    exp_err = 0;
  endtask

  task automatic test_single_frame();
    logic [VEC_W-1:0] a, b;
    int acc, rc, st;
    bit got;
    logic [RES_W-1:0] rd, m_rd;
    logic rt, rm, m_to, m_mm;
    logic [FRAME_W-1:0] fr;
    a = 64'h123456789abcdef0;
    b = 64'hfedcba9876543210;
    do_frame(a, b, 19'h18350, 3, 19'h18350, acc, got, rc, rd, rt, rm);
    model_resp(3, 19'h18350, 19'h18350, m_to, m_rd, m_mm);
    st = pop_start();
    fr = pop_frame();
    n_tests++;
    if (acc < 0 || st !== acc + 1) begin
      n_fail++;
      $display("FAIL single_start: got start cycle %0d, want %0d", st, acc + 1);
    end
    n_tests++;
    if (fr !== {b, a}) begin
      n_fail++;
      $display("FAIL single_frame_bits: got %h, want %h", fr, {b, a});
    end
    n_tests++;
    if (!got || rc !== model_resp_cyc(acc, 3) || rd !== 19'h18350 || rt !== 1'b0 || rm !== m_mm) begin
      n_fail++;
      $display("FAIL single_resp: got ok=%b cyc=%0d data=%h to=%b mm=%b, want cyc=%0d data=18350 to=0 mm=%b",
               got, rc, rd, rt, rm, model_resp_cyc(acc, 3), m_mm);
    end
    repeat (6) @(posedge clk);
    #1;
    n_tests++;
    if (resp_cyc_q.size() != 0 || start_cyc_q.size() != 0 || res_data !== 19'h18350 || res_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL single_hold: got extra_resp=%0d extra_start=%0d data=%h to=%b, want 0 0 18350 0",
               resp_cyc_q.size(), start_cyc_q.size(), res_data, res_timeout);
    end
    n_tests++;
    if (err_count !== 16'(exp_err)) begin
      n_fail++;
      $display("FAIL single_err_count: got %0d, want %0d", err_count, exp_err);
    end
  endtask

  task automatic test_check_en();
    int acc, rc;
    bit got;
    logic [RES_W-1:0] rd, m_rd;
    logic rt, rm, m_to, m_mm;
    do_frame({$urandom(), $urandom()}, {$urandom(), $urandom()}, 19'h18350, 3, 19'h18351,
             acc, got, rc, rd, rt, rm);
    model_resp(3, 19'h18351, 19'h18350, m_to, m_rd, m_mm);
    void'(pop_start());
    void'(pop_frame());
    n_tests++;
    if (!got || rd !== 19'h18351 || rt !== 1'b0 || rm !== m_mm) begin
      n_fail++;
      $display("FAIL check_mismatch: got ok=%b data=%h to=%b mm=%b, want data=18351 to=0 mm=%b",
               got, rd, rt, rm, m_mm);
    end
    n_tests++;
    if (err_count !== 16'(exp_err)) begin
      n_fail++;
      $display("FAIL check_err_after_bad: got %0d, want %0d", err_count, exp_err);
    end
    do_frame({$urandom(), $urandom()}, {$urandom(), $urandom()}, 19'h00777, 5, 19'h00777,
             acc, got, rc, rd, rt, rm);
    model_resp(5, 19'h00777, 19'h00777, m_to, m_rd, m_mm);
    void'(pop_start());
    void'(pop_frame());
    n_tests++;
    if (!got || rd !== 19'h00777 || rm !== m_mm || err_count !== 16'(exp_err)) begin
      n_fail++;
      $display("FAIL check_match: got ok=%b data=%h mm=%b err=%0d, want data=00777 mm=%b err=%0d",
               got, rd, rm, err_count, m_mm, exp_err);
    end
  endtask

  task automatic test_reset_mid_shift();
    int acc;
    logic [RES_W+22:0] outs;
    core_lat_q.push_back(3);
    core_res_q.push_back(19'h00abc);
    drive_vec({$urandom(), $urandom()}, {$urandom(), $urandom()}, 19'h00abc, 1'b0, acc);
    repeat (40) @(posedge clk);
    #1;
    n_tests++;
    if (start_cyc_q.size() != 1 || acc < 0) begin
      n_fail++;
      $display("FAIL mid_shift_started: got starts=%0d acc=%0d, want 1 start", start_cyc_q.size(), acc);
    end
    Reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outs = {vec_ready, Start, SerialData, res_valid, res_timeout, mismatch, res_data, err_count};
    n_tests++;
    if (outs !== '0 || dbg_state !== serial_dp_pkg::IDLE) begin
      n_fail++;
      $display("FAIL mid_shift_reset_outputs: got outs=%h state=%0d, want outs=0 state=0", outs, dbg_state);
    end
    @(posedge clk); #1;
    Reset = 1'b0;
    exp_err = 0;
    @(negedge clk);
    n_tests++;
    if (vec_ready !== 1'b1 || dbg_state !== serial_dp_pkg::IDLE) begin
      n_fail++;
      $display("FAIL mid_shift_ready: got vec_ready=%b state=%0d, want 1 0", vec_ready, dbg_state);
    end
    sd_stray = 0;
    repeat (200) @(posedge clk);
    #1;
    n_tests++;
    if (start_cyc_q.size() != 0 || resp_cyc_q.size() != 0 || sd_stray != 0) begin
      n_fail++;
      $display("FAIL mid_shift_quiet: got starts=%0d resps=%0d stray_bits=%0d, want 0 0 0",
               start_cyc_q.size(), resp_cyc_q.size(), sd_stray);
    end
  endtask

  task automatic test_back_to_back();
    logic [VEC_W-1:0] a[3], b[3];
    logic [RES_W-1:0] r[3];
    int acc[3], st[3];
    int rc;
    bit got;
    logic [RES_W-1:0] rd, m_rd;
    logic rt, rm, m_to, m_mm;
    logic [FRAME_W-1:0] fr;
    int rdy;
    for (int k = 0; k < 3; k++) begin
      a[k] = {$urandom(), $urandom()};
      b[k] = {$urandom(), $urandom()};
      r[k] = RES_W'($urandom());
      core_lat_q.push_back(3);
      core_res_q.push_back(r[k]);
    end
    ready_cycles = 0;
    for (int k = 0; k < 3; k++) drive_vec(a[k], b[k], r[k], (k < 2), acc[k]);
    for (int k = 0; k < 3; k++) begin
      wait_resp(got, rc, rd, rt, rm);
      if (k == 2) rdy = ready_cycles;
      model_resp(3, r[k], r[k], m_to, m_rd, m_mm);
      n_tests++;
      if (!got || rc !== model_resp_cyc(acc[k], 3) || rd !== m_rd || rt !== m_to || rm !== m_mm) begin
        n_fail++;
        $display("FAIL b2b_resp%0d: got ok=%b cyc=%0d data=%h to=%b mm=%b, want cyc=%0d data=%h to=%b mm=%b",
                 k, got, rc, rd, rt, rm, model_resp_cyc(acc[k], 3), m_rd, m_to, m_mm);
      end
      fr = pop_frame();
      n_tests++;
      if (fr !== {b[k], a[k]}) begin
        n_fail++;
        $display("FAIL b2b_frame%0d: got %h, want %h", k, fr, {b[k], a[k]});
      end
    end
    n_tests++;
    if (rdy != 3) begin
      n_fail++;
      $display("FAIL b2b_ready_cycles: got %0d, want 3", rdy);
    end
    n_tests++;
    if (start_cyc_q.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_start_count: got %0d, want 3", start_cyc_q.size());
    end
    for (int k = 0; k < 3; k++) st[k] = pop_start();
    n_tests++;
    if (st[1] - st[0] != FRAME_W + 3 + 2 || st[2] - st[1] != FRAME_W + 3 + 2) begin
      n_fail++;
      $display("FAIL b2b_start_spacing: got %0d %0d, want %0d", st[1] - st[0], st[2] - st[1], FRAME_W + 5);
    end
  endtask

  task automatic test_timeout();
    int acc, rc;
    bit got;
    logic [RES_W-1:0] rd, m_rd, r;
    logic rt, rm, m_to, m_mm;
    logic [VEC_W-1:0] a, b;
    do_frame({$urandom(), $urandom()}, {$urandom(), $urandom()}, 19'h00123, 0, 19'h00123,
             acc, got, rc, rd, rt, rm);
    model_resp(0, 19'h00123, 19'h00123, m_to, m_rd, m_mm);
    void'(pop_start());
    void'(pop_frame());
    n_tests++;
    if (!got || rc !== acc + FRAME_W + 1 + TIMEOUT || rd !== '0 || rt !== 1'b1 || rm !== m_mm) begin
      n_fail++;
      $display("FAIL timeout_resp: got ok=%b cyc=%0d data=%h to=%b mm=%b, want cyc=%0d data=0 to=1 mm=%b",
               got, rc, rd, rt, rm, acc + FRAME_W + 1 + TIMEOUT, m_mm);
    end
    a = {$urandom(), $urandom()};
    b = {$urandom(), $urandom()};
    r = RES_W'($urandom());
    do_frame(a, b, r, 5, r, acc, got, rc, rd, rt, rm);
    model_resp(5, r, r, m_to, m_rd, m_mm);
    void'(pop_start());
    n_tests++;
    if (!got || rc !== model_resp_cyc(acc, 5) || rd !== r || rt !== 1'b0 || pop_frame() !== {b, a}) begin
      n_fail++;
      $display("FAIL timeout_recover: got ok=%b cyc=%0d data=%h to=%b, want cyc=%0d data=%h to=0",
               got, rc, rd, rt, model_resp_cyc(acc, 5), r);
    end
    n_tests++;
    if (err_count !== 16'(exp_err)) begin
      n_fail++;
      $display("FAIL timeout_err_count: got %0d, want %0d", err_count, exp_err);
    end
  endtask

  task automatic test_done_edges();
    int acc, rc;
    bit got;
    logic [RES_W-1:0] rd, m_rd, r;
    logic rt, rm, m_to, m_mm;
    // Spurious Done mid-shift, real Done in the last cycle of the wait window.
    r = 19'h2a5c3;
    spur_bit = 50;
    do_frame({$urandom(), $urandom()}, {$urandom(), $urandom()}, r, TIMEOUT, r,
             acc, got, rc, rd, rt, rm);
    spur_bit = -1;
    model_resp(TIMEOUT, r, r, m_to, m_rd, m_mm);
    void'(pop_start());
    void'(pop_frame());
    n_tests++;
    if (!got || rc !== model_resp_cyc(acc, TIMEOUT) || rd !== r || rt !== 1'b0 || rm !== m_mm) begin
      n_fail++;
      $display("FAIL done_last_cycle: got ok=%b cyc=%0d data=%h to=%b mm=%b, want cyc=%0d data=%h to=0 mm=%b",
               got, rc, rd, rt, rm, model_resp_cyc(acc, TIMEOUT), r, m_mm);
    end
    // Done one cycle too late: timeout already taken.
    r = 19'h05a5a;
    do_frame({$urandom(), $urandom()}, {$urandom(), $urandom()}, r, TIMEOUT + 1, r,
             acc, got, rc, rd, rt, rm);
    model_resp(TIMEOUT + 1, r, r, m_to, m_rd, m_mm);
    void'(pop_start());
    void'(pop_frame());
    n_tests++;
    if (!got || rc !== model_resp_cyc(acc, TIMEOUT + 1) || rd !== '0 || rt !== 1'b1 || rm !== m_mm) begin
      n_fail++;
      $display("FAIL done_too_late: got ok=%b cyc=%0d data=%h to=%b mm=%b, want cyc=%0d data=0 to=1 mm=%b",
               got, rc, rd, rt, rm, model_resp_cyc(acc, TIMEOUT + 1), m_mm);
    end
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (resp_cyc_q.size() != 0 || err_count !== 16'(exp_err)) begin
      n_fail++;
      $display("FAIL done_edges_after: got extra_resp=%0d err=%0d, want 0 %0d",
               resp_cyc_q.size(), err_count, exp_err);
    end
  endtask

  task automatic test_random();
    int acc, rc, lat;
    bit got;
    logic [RES_W-1:0] rd, m_rd, r, e;
    logic rt, rm, m_to, m_mm;
    logic [VEC_W-1:0] a, b;
    logic [FRAME_W-1:0] fr;
    for (int k = 0; k < 8; k++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      r = RES_W'($urandom());
      e = ($urandom_range(0, 1) == 1) ? r : RES_W'($urandom());
      lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TIMEOUT + 2));
      do_frame(a, b, e, lat, r, acc, got, rc, rd, rt, rm);
      model_resp(lat, r, e, m_to, m_rd, m_mm);
      void'(pop_start());
      fr = pop_frame();
      n_tests++;
      if (!got || rc !== model_resp_cyc(acc, lat) || rd !== m_rd || rt !== m_to || rm !== m_mm || fr !== {b, a}) begin
        n_fail++;
        $display("FAIL random%0d lat=%0d: got ok=%b cyc=%0d data=%h to=%b mm=%b frame_ok=%b, want cyc=%0d data=%h to=%b mm=%b",
                 k, lat, got, rc, rd, rt, rm, (fr === {b, a}), model_resp_cyc(acc, lat), m_rd, m_to, m_mm);
      end
    end
    n_tests++;
    if (err_count !== 16'(exp_err)) begin
      n_fail++;
      $display("FAIL random_err_count: got %0d, want %0d", err_count, exp_err);
    end
  endtask

  initial begin
    Reset = 1'b1;
    vec_valid = 1'b0;
    vec_a = '0;
    vec_b = '0;
    exp_result = '0;
    test_reset();
    test_single_frame();
    test_check_en();
    test_reset_mid_shift();
    test_back_to_back();
    test_timeout();
    test_done_edges();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_vector_driver.md
Name: serial_vector_driver

Overview:
Parametrised serial stimulus/response engine for the bit-serial dot-product datapath. Accepts an operand pair (A, B) on a valid/ready load port and pulses Start. It then shifts the frame {B, A} LSB-first on SerialData, waits for Done, and captures DataOut. It sits between a vector source (bench or control FSM) and the serial dot-product core, and adds back-to-back operation, a Done timeout, and optional result checking.

Parameters:
NUM_ELEM, 8, elements per operand vector
ELEM_W, 8, bits per element
RES_W, 19, DataOut width (8 x 8-bit products fit in 19 bits)
TIMEOUT, 256, max cycles in WAIT before abort (>=1)

Ports:
clk  input  1  clock, all logic on posedge
Reset  input  1  synchronous, active-high reset
vec_valid  input  1  operand pair available
vec_ready  output  1  high only in IDLE and not in Reset
vec_a  input  NUM_ELEM*ELEM_W  operand A, element 0 in LSBs
vec_b  input  NUM_ELEM*ELEM_W  operand B, element 0 in LSBs
exp_result  input  RES_W  expected result, sampled with the vector; ignored without CHECK_EN
SerialData  output  1  serial frame bit to core
Start  output  1  one-cycle frame start to core
DataOut  input  RES_W  core result
Done  input  1  core result valid
res_valid  output  1  one-cycle result strobe
res_data  output  RES_W  captured DataOut (0 on timeout)
res_timeout  output  1  qualifies res_valid; Done never arrived
mismatch  output  1  CHECK_EN only; qualifies res_valid
err_count  output  16  CHECK_EN only; saturating mismatch+timeout count

Behaviour:
- FRAME_W = 2*NUM_ELEM*ELEM_W; frame = {vec_b, vec_a}, bit 0 sent first.
- Reset (synchronous, in any state, including mid-shift or mid-wait): state=IDLE; the shift register, counters, SerialData, Start, res_valid, res_data, res_timeout, mismatch, and err_count all go to 0. vec_ready is 0 during the Reset cycle.
- States: IDLE, SHIFT, WAIT, RESP.
- IDLE: vec_ready=1, SerialData=0. On the posedge with vec_valid&&vec_ready, load the frame and exp_result, clear bit_cnt, and go to SHIFT.
- SHIFT, cycle 0: Start=1 and SerialData=frame[0].
- SHIFT, cycles 1..FRAME_W-1: Start=0 and SerialData=frame[i]. The register shifts right with zero fill. After bit_cnt==FRAME_W-1, go to WAIT.
- Start is high for exactly one cycle per frame, and the first data bit is coincident with it. Vector accept to Start is 1 cycle.
- Done is ignored in SHIFT and IDLE.
- WAIT: SerialData=0. The timer increments each cycle. On Done=1, capture DataOut into res_data and go to RESP. If the timer reaches TIMEOUT-1 with no Done, set res_data=0 and res_timeout=1, then go to RESP. If Done and the timeout occur in the same cycle, Done wins.
- RESP: res_valid=1 for one cycle, then IDLE. res_data and res_timeout hold until the next RESP.
- Throughput: one result per FRAME_W+W+2 cycles, where W is the core's Done latency after the last bit.
- Counter widths: bit_cnt uses $clog2(FRAME_W); the timer uses $clog2(TIMEOUT+1).

Optional Feature:
Macro SERIAL_VECTOR_DRIVER_CHECK_EN.
- Defined: in RESP, mismatch = timeout OR (res_data != latched exp_result). err_count increments when mismatch=1 and saturates at 16'hFFFF.
- Undefined: mismatch and err_count are tied to 0, the exp_result latch is removed, and the ports remain.

Decomposition:
- Package serial_dp_pkg: state enum (IDLE, SHIFT, WAIT, RESP), default NUM_ELEM/ELEM_W/RES_W constants, and a FRAME_W function.
- Sub-module piso_shift_reg (parallel load, LSB-first serial out, zero fill, parameter WIDTH) instantiated once.
- FSM, timer and checker stay in the top level.

Test Plan:
- Reset: assert Reset for 2 cycles mid-SHIFT -> all outputs 0, state IDLE; vec_ready=1 the cycle after Reset drops; no Start.
- Single frame, defaults: vec_a=64'h123456789abcdef0, vec_b=64'hfedcba9876543210, core model returns 19'h18350 with Done 3 cycles after the last bit -> Start 1 cycle after accept; 128 serial bits match {B,A} LSB-first; res_valid once with res_data=19'h18350, res_timeout=0.
- Back-to-back: hold vec_valid=1 for 3 vectors -> vec_ready is high only in IDLE; exactly 3 Start pulses, each 128 bits apart plus wait; 3 res_valid in order.
- Timeout: TIMEOUT=16, core never asserts Done -> res_valid 16 cycles after WAIT entry, res_timeout=1, res_data=0; next vector accepted normally.
- Done edge cases: Done pulsed during SHIFT is ignored. Done in the final timeout cycle gives res_timeout=0 and the captured data.
- CHECK_EN defined: exp_result=19'h18350 with core returning 19'h18351 -> mismatch=1, err_count=1; a matching frame leaves err_count=1.
